// File: rtl/shift_pattern_controller.sv
// LED pattern sequencer: owns the pattern register and steps it per prescaled tick
// in one of four modes (fill, rotate, bounce, hold) selected by debounced-edge buttons.
module shift_pattern_controller #(
  parameter int WIDTH = 12,
  parameter int DIV_W = 23
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             btn_data,
  input  logic             btn_mode,
  input  logic             btn_clear,
  input  logic [1:0]       speed,
  output logic [WIDTH-1:0] pattern,
  output logic [1:0]       mode,
  output logic             tick
);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    ROTATE = 2'd1,
    BOUNCE = 2'd2,
    HOLD   = 2'd3
  } mode_t;

  typedef enum logic {
    DOWN = 1'b0,
    UP   = 1'b1
  } dir_t;

  localparam logic [WIDTH-1:0] DOT = {1'b1, {(WIDTH-1){1'b0}}};

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] tick_mask;
  // Per button: [0]=first sync flop, [1]=synchronized level, [2]=delayed copy for edge detect.
  logic [2:0]       data_sync;
  logic [2:0]       mode_sync;
  logic [2:0]       clear_sync;
  mode_t            state;
  mode_t            next_state;
  dir_t             dir;
  logic             tick_c;
  logic             mode_rise;
  logic             clear_rise;
  logic             data_s;

  // Faster speeds compare fewer low bits of the same counter, so a speed change takes effect at once.
  assign tick_mask  = {DIV_W{1'b1}} >> speed;
  assign tick_c     = ((cnt & tick_mask) == '0);
  assign data_s     = data_sync[1];
  assign mode_rise  = mode_sync[1] & ~mode_sync[2];
  assign clear_rise = clear_sync[1] & ~clear_sync[2];
  assign mode       = state;

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = FILL;
    case (state)
      FILL:    next_state = ROTATE;
      ROTATE:  next_state = BOUNCE;
      BOUNCE:  next_state = HOLD;
      HOLD:    next_state = FILL;
      default: next_state = FILL;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt        <= '0;
      tick       <= 1'b0;
      data_sync  <= '0;
      mode_sync  <= '0;
      clear_sync <= '0;
      state      <= FILL;
      dir        <= DOWN;
      pattern    <= '0;
    end else begin
      cnt        <= cnt + 1'b1;
      tick       <= tick_c;
      data_sync  <= {data_sync[1:0], btn_data};
      mode_sync  <= {mode_sync[1:0], btn_mode};
      clear_sync <= {clear_sync[1:0], btn_clear};

      // Priority: mode change, then clear, then the per-tick step.
      if (mode_rise) begin
        state <= next_state;
        if (next_state == BOUNCE) begin
          pattern <= DOT;
          dir     <= DOWN;
        end else if (clear_rise) begin
          pattern <= '0;
        end
      end else if (clear_rise) begin
        if (state == BOUNCE) begin
          pattern <= DOT;
          dir     <= DOWN;
        end else begin
          pattern <= '0;
        end
      end else if (tick_c) begin
        case (state)
          FILL:   pattern <= {data_s, pattern[WIDTH-1:1]};
          ROTATE: pattern <= {pattern[0], pattern[WIDTH-1:1]};
          BOUNCE: begin
            // Turn around on reaching an endpoint so each end is lit for exactly one tick.
            if (dir == DOWN) begin
              if (pattern[0]) begin
                dir     <= UP;
                pattern <= pattern << 1;
              end else begin
                pattern <= pattern >> 1;
              end
            end else begin
              if (pattern[WIDTH-1]) begin
                dir     <= DOWN;
                pattern <= pattern >> 1;
              end else begin
                pattern <= pattern << 1;
              end
            end
          end
          default: pattern <= pattern;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shift_pattern_controller.sv
// Directed bench for shift_pattern_controller (WIDTH=12, DIV_W=4): fill, rotate,
// bounce, hold, clear/mode interaction, speed change and mid-run reset.
module tb_shift_pattern_controller;

  localparam int WIDTH = 12;
  localparam int DIV_W = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             btn_data = 1'b0;
  logic             btn_mode = 1'b0;
  logic             btn_clear = 1'b0;
  logic [1:0]       speed = 2'd0;
  logic [WIDTH-1:0] pattern;
  logic [1:0]       mode;
  logic             tick;

  int checks = 0;
  int failures = 0;

  shift_pattern_controller #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_data  (btn_data),
    .btn_mode  (btn_mode),
    .btn_clear (btn_clear),
    .speed     (speed),
    .pattern   (pattern),
    .mode      (mode),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until tick is seen high; cycles = edges taken, bounded.
  task automatic wait_tick(output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (tick !== 1'b1 && cycles < 64);
    if (tick !== 1'b1) check("tick_timeout", {31'd0, tick}, 32'd1);
  endtask

  // Called just after a tick edge at speed 0; the pulse is aligned so it acts on the next tick edge.
  task automatic pulse_at_tick(input logic m, input logic c, output logic [1:0] mode_edge2);
    repeat (13) step();
    btn_mode  = m;
    btn_clear = c;
    step();
    btn_mode  = 1'b0;
    btn_clear = 1'b0;
    step();
    mode_edge2 = mode;
    step();
  endtask

  initial begin
    int               cyc;
    logic [WIDTH-1:0] exp_pat;
    logic [1:0]       m2;

    // 1. reset, then fill with ones
    btn_data = 1'b1;
    repeat (3) step();
    check("reset_pattern", pattern, 0);
    check("reset_mode", mode, 0);
    check("reset_tick", tick, 0);
    reset_n = 1'b1;
    wait_tick(cyc);
    check("first_tick_latency", cyc, 1);
    check("first_tick_pattern", pattern, 0);
    exp_pat = '0;
    for (int i = 0; i < 12; i++) begin
      wait_tick(cyc);
      exp_pat = {1'b1, exp_pat[WIDTH-1:1]};
      check($sformatf("fill_period_%0d", i), cyc, 16);
      check($sformatf("fill_pattern_%0d", i), pattern, exp_pat);
    end
    check("fill_full", pattern, 32'hFFF);

    // 2. load 0x801 through FILL, then advance to ROTATE
    for (int i = 0; i < 12; i++) begin
      btn_data = (i == 0 || i == 11);
      wait_tick(cyc);
    end
    btn_data = 1'b0;
    check("fill_801", pattern, 32'h801);
    pulse_at_tick(1'b1, 1'b0, m2);
    check("mode_edge2_unchanged", m2, 0);
    check("mode_rotate", mode, 1);
    check("mode_change_no_shift", pattern, 32'h801);
    check("mode_change_tick", tick, 1);
    wait_tick(cyc);
    check("rotate_1", pattern, 32'hC00);
    wait_tick(cyc);
    check("rotate_2", pattern, 32'h600);

    // 4. clear aligned with tick in ROTATE
    pulse_at_tick(1'b0, 1'b1, m2);
    check("clear_beats_tick", pattern, 0);
    check("clear_mode_kept", mode, 1);
    wait_tick(cyc);
    check("rotate_zero_stays", pattern, 0);

    // 5. mode and clear together in ROTATE -> BOUNCE with dot
    pulse_at_tick(1'b1, 1'b1, m2);
    check("mode_clear_mode", mode, 2);
    check("mode_clear_dot", pattern, 32'h800);

    // 3. bounce traversal
    for (int k = 1; k <= 23; k++) begin
      wait_tick(cyc);
      if (k <= 11)      exp_pat = 12'h800 >> k;
      else if (k <= 22) exp_pat = 12'h001 << (k - 11);
      else              exp_pat = 12'h400;
      check($sformatf("bounce_%0d", k), pattern, exp_pat);
    end

    // clear in BOUNCE reloads the dot and direction
    pulse_at_tick(1'b0, 1'b1, m2);
    check("bounce_clear_dot", pattern, 32'h800);
    wait_tick(cyc);
    check("bounce_clear_dir_down", pattern, 32'h400);

    // HOLD keeps the pattern across ticks
    pulse_at_tick(1'b1, 1'b0, m2);
    check("hold_mode", mode, 3);
    check("hold_entry_keep", pattern, 32'h400);
    wait_tick(cyc);
    check("hold_tick_keep", pattern, 32'h400);
    pulse_at_tick(1'b1, 1'b0, m2);
    check("wrap_fill_mode", mode, 0);
    check("fill_entry_keep", pattern, 32'h400);
    pulse_at_tick(1'b1, 1'b0, m2);
    check("rotate_again", mode, 1);
    pulse_at_tick(1'b1, 1'b0, m2);
    check("bounce_again_mode", mode, 2);
    check("bounce_again_dot", pattern, 32'h800);

    // 6. speed 3 and reset mid-BOUNCE
    speed = 2'd3;
    wait_tick(cyc);
    check("fast_first_gap", cyc, 2);
    check("fast_first_pattern", pattern, 32'h400);
    wait_tick(cyc);
    check("fast_period", cyc, 2);
    check("fast_pattern", pattern, 32'h200);
    step();
    reset_n = 1'b0;
    step();
    check("midrun_reset_pattern", pattern, 0);
    check("midrun_reset_mode", mode, 0);
    check("midrun_reset_tick", tick, 0);
    reset_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
